fifo_write_arbiter: RTL and testbench

Round-robin arbiter that shares the write port of the team's `fifo` block among `NUM_REQ` requesters in the `clock_in` domain. It selects one requester at a time and holds the grant for a bounded burst. It muxes the granted requester's data and valid onto the FIFO `data_in` / `data_in_valid` inputs and applies backpressure from `data_in_full` to the granted requester only. It sits directly in front of the FIFO write side, with one instance per shared FIFO.

---
 rtl/fifo_write_arbiter.sv | 131 +++++++++++++
 tb/tb_fifo_write_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters, with bounded bursts per grant.
// Define FIFO_ARB_PACKET_EN to hold each grant until a beat flagged req_last is accepted.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clock_in,
    input  logic                          rst_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
`ifdef FIFO_ARB_PACKET_EN
    input  logic [NUM_REQ-1:0]            req_last,
`endif
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          data_in_valid,
    input  logic                          data_in_full,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
`ifndef FIFO_ARB_PACKET_EN
    localparam logic [7:0] BURST_END = 8'(MAX_BURST - 1);
`endif

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  grant_idx, grant_idx_next;
    logic [IDX_W-1:0]  last_idx, last_idx_next;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic [7:0]        beat_cnt, beat_cnt_next;
    logic              sel_valid;
    logic              accept;
    logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
        assign req_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Cyclic search starting just after the most recently granted requester
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        pick_idx   = last_idx;
        pick_found = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(last_idx) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!pick_found && req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_valid     = req_valid[grant_idx];
        busy          = (state == GRANT);
        data_in       = req_word[grant_idx];
        data_in_valid = busy && sel_valid;
        accept        = data_in_valid && !data_in_full;
        req_ready     = '0;
        grant         = '0;
        if (busy) begin
            req_ready[grant_idx] = sel_valid & ~data_in_full;
            grant[grant_idx]     = 1'b1;
        end
    end

    always_comb begin
        state_next     = state;
        grant_idx_next = grant_idx;
        last_idx_next  = last_idx;
        beat_cnt_next  = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_idx_next = pick_idx;
                    last_idx_next  = pick_idx;
                    beat_cnt_next  = 8'd0;
                    state_next     = GRANT;
                end
            end
            GRANT: begin
`ifdef FIFO_ARB_PACKET_EN
                // Grant survives valid gaps; only the accepted last beat ends the packet
                if (accept) begin
                    if (beat_cnt != 8'hFF) begin
                        beat_cnt_next = beat_cnt + 8'd1;
                    end
                    if (req_last[grant_idx]) begin
                        state_next = IDLE;
                    end
                end
`else
                if (accept) begin
                    if (beat_cnt == BURST_END) begin
                        state_next = IDLE;
                    end else begin
                        beat_cnt_next = beat_cnt + 8'd1;
                    end
                end else if (!sel_valid) begin
                    state_next = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (rst_in) begin
            state     <= IDLE;
            grant_idx <= '0;
            last_idx  <= IDX_W'(NUM_REQ - 1);
            beat_cnt  <= 8'd0;
        end else begin
            state     <= state_next;
            grant_idx <= grant_idx_next;
            last_idx  <= last_idx_next;
            beat_cnt  <= beat_cnt_next;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed, table-driven bench for fifo_write_arbiter (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=8).
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;

    logic              clock_in = 1'b0;
    logic              rst_in;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
`ifdef FIFO_ARB_PACKET_EN
    logic [NR-1:0]     req_last;
`endif
    logic [DW-1:0]     data_in;
    logic              data_in_valid;
    logic              data_in_full;
    logic [NR-1:0]     grant;
    logic              busy;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic       full;
        logic [3:0] last;
        logic [7:0] dat;
        logic [3:0] egrant;
        logic       edv;
        logic [3:0] eready;
        logic       ebusy;
    } vec_t;

    vec_t vecs[$];

    fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(8)) dut (
        .clock_in      (clock_in),
        .rst_in        (rst_in),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
`ifdef FIFO_ARB_PACKET_EN
        .req_last      (req_last),
`endif
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_full  (data_in_full),
        .grant         (grant),
        .busy          (busy)
    );

    always #5 clock_in = ~clock_in;

    function automatic vec_t makeVec(input logic r, input logic [3:0] v, input logic f,
                                     input logic [3:0] l, input logic [7:0] d,
                                     input logic [3:0] g, input logic dv, input logic [3:0] rdy);
        vec_t t;
        t.rst = r; t.valid = v; t.full = f; t.last = l; t.dat = d;
        t.egrant = g; t.edv = dv; t.eready = rdy; t.ebusy = (g != 4'b0000);
        return t;
    endfunction

    task automatic addVec(input logic r, input logic [3:0] v, input logic f,
                          input logic [3:0] g, input logic dv, input logic [3:0] rdy);
        vecs.push_back(makeVec(r, v, f, 4'b0000, 8'(vecs.size()), g, dv, rdy));
    endtask

    task automatic applyStimulus(input vec_t t);
        rst_in       = t.rst;
        req_valid    = t.valid;
        data_in_full = t.full;
`ifdef FIFO_ARB_PACKET_EN
        req_last     = t.last;
`endif
        for (int i = 0; i < NR; i++) begin
            req_data[i*DW +: DW] = {8'(8'hA0 + i), 16'h0000, t.dat};
        end
    endtask

    task automatic checkOutput(input vec_t t, input string name);
        logic [DW-1:0] exp_data;
        exp_data = '0;
        for (int i = 0; i < NR; i++) begin
            if (t.egrant[i]) exp_data = {8'(8'hA0 + i), 16'h0000, t.dat};
        end
        tests_run++;
        if (grant !== t.egrant) begin
            tests_failed++;
            $display("[TB] FAIL %s grant: got %b expected %b", name, grant, t.egrant);
        end
        tests_run++;
        if (data_in_valid !== t.edv) begin
            tests_failed++;
            $display("[TB] FAIL %s data_in_valid: got %b expected %b", name, data_in_valid, t.edv);
        end
        tests_run++;
        if (req_ready !== t.eready) begin
            tests_failed++;
            $display("[TB] FAIL %s req_ready: got %b expected %b", name, req_ready, t.eready);
        end
        tests_run++;
        if (busy !== t.ebusy) begin
            tests_failed++;
            $display("[TB] FAIL %s busy: got %b expected %b", name, busy, t.ebusy);
        end
        if (t.edv) begin
            tests_run++;
            if (data_in !== exp_data) begin
                tests_failed++;
                $display("[TB] FAIL %s data_in: got %h expected %h", name, data_in, exp_data);
            end
        end
    endtask

    // One vector per clock: drive after the edge, compare mid-cycle, then let the edge commit
    task automatic runVec(input vec_t t, input string name);
        applyStimulus(t);
        @(negedge clock_in);
        checkOutput(t, name);
        @(posedge clock_in);
        #1;
    endtask

    initial begin
        rst_in       = 1'b1;
        req_valid    = '0;
        data_in_full = 1'b0;
        req_data     = '0;
`ifdef FIFO_ARB_PACKET_EN
        req_last     = '0;
`endif
        repeat (2) @(posedge clock_in);
        #1;

`ifdef FIFO_ARB_PACKET_EN
        // 12-beat packet from requester 0 with a two-cycle valid gap after beat 5
        runVec(makeVec(1, 4'b1111, 0, 4'b0000, 8'd0, 4'b0000, 0, 4'b0000), "pkt_reset");
        runVec(makeVec(0, 4'b0001, 0, 4'b0000, 8'd0, 4'b0000, 0, 4'b0000), "pkt_idle");
        for (int b = 1; b <= 12; b++) begin
            if (b == 6) begin
                runVec(makeVec(0, 4'b0000, 0, 4'b0000, 8'd0, 4'b0001, 0, 4'b0000), "pkt_gap0");
                runVec(makeVec(0, 4'b0000, 0, 4'b0000, 8'd0, 4'b0001, 0, 4'b0000), "pkt_gap1");
            end
            runVec(makeVec(0, 4'b0001, 0, (b == 12) ? 4'b0001 : 4'b0000, 8'(b),
                           4'b0001, 1, 4'b0001), $sformatf("pkt_beat%0d", b));
        end
        runVec(makeVec(0, 4'b0000, 0, 4'b0000, 8'd0, 4'b0000, 0, 4'b0000), "pkt_release");
`else
        // Reset holds IDLE even with requests; then requester 0 alone takes an 8-beat burst
        addVec(1, 4'b1111, 0, 4'b0000, 0, 4'b0000);
        addVec(0, 4'b0001, 0, 4'b0000, 0, 4'b0000);
        for (int i = 0; i < 8; i++) addVec(0, 4'b0001, 0, 4'b0001, 1, 4'b0001);
        addVec(0, 4'b0001, 0, 4'b0000, 0, 4'b0000);
        addVec(0, 4'b0000, 0, 4'b0001, 0, 4'b0000);
        addVec(0, 4'b0000, 0, 4'b0000, 0, 4'b0000);
        // All four requesting: rotation 1,2,3,0 with one bubble between bursts
        for (int g = 1; g <= 4; g++) begin
            addVec(0, 4'b1111, 0, 4'b0000, 0, 4'b0000);
            for (int i = 0; i < 8; i++)
                addVec(0, 4'b1111, 0, 4'(1 << (g % 4)), 1, 4'(1 << (g % 4)));
        end
        addVec(0, 4'b0000, 0, 4'b0000, 0, 4'b0000);
        // Requester 2 with five full-stall cycles after beat 3
        addVec(0, 4'b0100, 0, 4'b0000, 0, 4'b0000);
        for (int i = 0; i < 3; i++) addVec(0, 4'b0100, 0, 4'b0100, 1, 4'b0100);
        for (int i = 0; i < 5; i++) addVec(0, 4'b0100, 1, 4'b0100, 1, 4'b0000);
        for (int i = 0; i < 5; i++) addVec(0, 4'b0100, 0, 4'b0100, 1, 4'b0100);
        addVec(0, 4'b0000, 0, 4'b0000, 0, 4'b0000);
        // Requester 1 drops valid after 3 beats while full is high; requester 2 is next
        addVec(0, 4'b0010, 0, 4'b0000, 0, 4'b0000);
        for (int i = 0; i < 3; i++) addVec(0, 4'b0010, 0, 4'b0010, 1, 4'b0010);
        addVec(0, 4'b0100, 1, 4'b0010, 0, 4'b0000);
        addVec(0, 4'b0100, 0, 4'b0000, 0, 4'b0000);
        addVec(0, 4'b0100, 0, 4'b0100, 1, 4'b0100);
        addVec(0, 4'b0000, 0, 4'b0100, 0, 4'b0000);
        addVec(0, 4'b0000, 0, 4'b0000, 0, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) runVec(vecs[i], $sformatf("vec%0d", i));

        // Reset during beat 4 of a burst from requester 3, then requester 0 regains priority
        runVec(makeVec(0, 4'b1111, 0, 4'b0000, 8'h40, 4'b0000, 0, 4'b0000), "rst_idle");
        for (int b = 1; b <= 3; b++)
            runVec(makeVec(0, 4'b1111, 0, 4'b0000, 8'(8'h40 + b), 4'b1000, 1, 4'b1000),
                   $sformatf("rst_beat%0d", b));
        runVec(makeVec(1, 4'b1111, 0, 4'b0000, 8'h44, 4'b1000, 1, 4'b1000), "rst_beat4");
        runVec(makeVec(0, 4'b1111, 0, 4'b0000, 8'h45, 4'b0000, 0, 4'b0000), "rst_after");
        runVec(makeVec(0, 4'b1111, 0, 4'b0000, 8'h46, 4'b0001, 1, 4'b0001), "rst_prio0");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
